// File: rtl/vdp_pkg.sv
// Shared encodings for the nouveau-vdp99 CPU read path: FSM states, status bit
// positions and port-select values.
package vdp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int STAT_F  = 7;
  localparam int STAT_5S = 6;
  localparam int STAT_C  = 5;

  localparam logic PORT_DATA   = 1'b0;
  localparam logic PORT_STATUS = 1'b1;

endpackage

// File: rtl/vdp_status_reg.sv
// VDP status register {F, 5S, C, num[4:0]}: set pulses win over the read-clear,
// and only flags present in the read snapshot are cleared.
module vdp_status_reg
  import vdp_pkg::*;
#(
  parameter logic [7:0] STATUS_RST = 8'h00
) (
  input  logic       phi,
  input  logic       reset_n,
  input  logic       vblank_set,
  input  logic       coinc_set,
  input  logic       fifth_set,
  input  logic [4:0] fifth_num,
  input  logic       clr,
  input  logic [7:5] snap,
  output logic [7:0] status
);

  logic [7:5] kill;
  assign kill = clr ? snap : 3'b000;

  always_ff @(negedge phi or negedge reset_n) begin
    if (!reset_n) begin
      status <= STATUS_RST;
    end else begin
      status[STAT_F]  <= vblank_set | (status[STAT_F]  & ~kill[STAT_F]);
      status[STAT_5S] <= fifth_set  | (status[STAT_5S] & ~kill[STAT_5S]);
      status[STAT_C]  <= coinc_set  | (status[STAT_C]  & ~kill[STAT_C]);
      // sprite number freezes once 5S is up so the CPU sees the first offender
      if (fifth_set && !status[STAT_5S]) status[4:0] <= fifth_num;
    end
  end

endmodule

// File: rtl/vdp_cpu_rd.sv
// CPU read responder for the nouveau-vdp99 data/status ports, state on negedge phi.
// Define VDP_RD_WAIT_EN to stall data-port reads via wait_n until buf_valid.
module vdp_cpu_rd
  import vdp_pkg::*;
#(
  parameter logic [7:0] STATUS_RST = 8'h00
) (
  input  logic       phi,
  input  logic       reset_n,
  input  logic       iorq,
  input  logic       rd,
  input  logic       mode,
  input  logic [7:0] buf_data,
  input  logic       buf_valid,
  input  logic       vblank_set,
  input  logic       coinc_set,
  input  logic       fifth_set,
  input  logic [4:0] fifth_num,
  input  logic       ie,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic       rd_tick,
  output logic       latch_reset,
  output logic       int_n,
  output logic       wait_n
);

`ifdef VDP_RD_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  state_t     state;
  logic       mode_q;
  logic       req;
  logic       clr;
  logic [7:0] status;

  assign req = iorq & rd;
  assign clr = (state == ST_DONE) && (mode_q == PORT_STATUS);

  // dout still holds the status snapshot in DONE, so it doubles as the clear mask
  vdp_status_reg #(.STATUS_RST(STATUS_RST)) u_status (
    .phi        (phi),
    .reset_n    (reset_n),
    .vblank_set (vblank_set),
    .coinc_set  (coinc_set),
    .fifth_set  (fifth_set),
    .fifth_num  (fifth_num),
    .clr        (clr),
    .snap       (dout[7:5]),
    .status     (status)
  );

  always_ff @(negedge phi or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      mode_q      <= PORT_DATA;
      dout        <= 8'h00;
      rd_tick     <= 1'b0;
      latch_reset <= 1'b0;
    end else begin
      rd_tick     <= 1'b0;
      latch_reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            state  <= ST_T1;
            mode_q <= mode;
            dout   <= (mode == PORT_STATUS) ? status : buf_data;
          end
        end
        ST_T1: begin
          if (!req)                                              state <= ST_IDLE;
          else if (WAIT_EN && mode_q == PORT_DATA && !buf_valid) state <= ST_WAIT;
          else                                                   state <= ST_HOLD;
        end
`ifdef VDP_RD_WAIT_EN
        ST_WAIT: begin
          dout <= buf_data;
          if (!req)           state <= ST_IDLE;
          else if (buf_valid) state <= ST_HOLD;
        end
`endif
        ST_HOLD: begin
          if (!req) begin
            state       <= ST_DONE;
            latch_reset <= 1'b1;
            rd_tick     <= (mode_q == PORT_DATA);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef VDP_RD_WAIT_EN
  assign wait_n = (state != ST_WAIT);
`else
  assign wait_n = 1'b1;
`endif

  assign dout_oe = req && (state == ST_T1 || state == ST_WAIT || state == ST_HOLD);
  assign int_n   = ~(status[STAT_F] & ie);

endmodule

// File: tb/tb_vdp_cpu_rd.sv
// Bench for vdp_cpu_rd: transaction-level reference model checked every phi cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_vdp_cpu_rd;

`ifdef VDP_RD_WAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic       phi = 1'b1, reset_n = 1'b0;
  logic       iorq = 1'b0, rd = 1'b0, mode = 1'b0;
  logic [7:0] buf_data = 8'h00;
  logic       buf_valid = 1'b1;
  logic       vblank_set = 1'b0, coinc_set = 1'b0, fifth_set = 1'b0, ie = 1'b0;
  logic [4:0] fifth_num = 5'd0;
  logic [7:0] dout;
  logic       dout_oe, rd_tick, latch_reset, int_n, wait_n;

  vdp_cpu_rd dut (
    .phi(phi), .reset_n(reset_n), .iorq(iorq), .rd(rd), .mode(mode),
    .buf_data(buf_data), .buf_valid(buf_valid), .vblank_set(vblank_set),
    .coinc_set(coinc_set), .fifth_set(fifth_set), .fifth_num(fifth_num), .ie(ie),
    .dout(dout), .dout_oe(dout_oe), .rd_tick(rd_tick), .latch_reset(latch_reset),
    .int_n(int_n), .wait_n(wait_n)
  );

  always #5 phi = ~phi;

  int nvec = 0, nerr = 0;
  int cnt_tick = 0, cnt_lr = 0, cnt_wait = 0;

  // Reference model: a read is "open" from acceptance until RD/IORQ drop; it
  // completes (pulses next cycle) only if it got past its first edge and was not stalled.
  bit         m_open = 0, m_past1 = 0, m_stall = 0, m_fin = 0, m_mode = 0;
  logic [7:0] m_dout = 8'h00, m_snap = 8'h00;
  bit         mF = 0, m5 = 0, mC = 0;
  logic [4:0] mnum = 5'd0;
  bit         q, clr, oF, o5, oC;
  logic [4:0] onum;

  always @(negedge phi or negedge reset_n) begin
    if (!reset_n) begin
      m_open = 0; m_past1 = 0; m_stall = 0; m_fin = 0; m_mode = 0;
      m_dout = 8'h00; mF = 0; m5 = 0; mC = 0; mnum = 5'd0;
    end else begin
      q   = iorq && rd;
      clr = m_fin && m_mode;
      oF = mF; o5 = m5; oC = mC; onum = mnum;
      mF = vblank_set || (oF && !(clr && m_snap[7]));
      m5 = fifth_set  || (o5 && !(clr && m_snap[6]));
      mC = coinc_set  || (oC && !(clr && m_snap[5]));
      if (fifth_set && !o5) mnum = fifth_num;
      if (m_fin) m_fin = 0;
      else if (!m_open) begin
        if (q) begin
          m_open = 1; m_past1 = 0; m_stall = 0; m_mode = mode;
          m_snap = {oF, o5, oC, onum};
          m_dout = mode ? m_snap : buf_data;
        end
      end else begin
        if (m_stall) m_dout = buf_data;
        if (!q) begin
          m_fin = m_past1 && !m_stall;
          m_open = 0; m_stall = 0;
        end else if (!m_past1) begin
          m_past1 = 1;
          m_stall = WEN && !m_mode && !buf_valid;
        end else if (m_stall && buf_valid) m_stall = 0;
      end
    end
  end

  // per-cycle compare, mid-phase after the driver has settled
  always @(posedge phi) begin
    logic e_oe, e_tick, e_int;
    logic [7:0] e_stat;
    #2;
    e_oe   = m_open && iorq && rd;
    e_tick = m_fin && !m_mode;
    e_int  = !(mF && ie);
    e_stat = {mF, m5, mC, mnum};
    nvec++;
    if (dout !== m_dout || dout_oe !== e_oe || rd_tick !== e_tick || latch_reset !== m_fin ||
        int_n !== e_int || wait_n !== !m_stall || dut.status !== e_stat) begin
      nerr++;
      $display("FAIL cycle @%0t: dout=%h/%h oe=%b/%b tick=%b/%b lr=%b/%b int_n=%b/%b wait_n=%b/%b status=%h/%h (got/want)",
               $time, dout, m_dout, dout_oe, e_oe, rd_tick, e_tick, latch_reset, m_fin,
               int_n, e_int, wait_n, !m_stall, dut.status, e_stat);
    end
    cnt_tick += int'(rd_tick);
    cnt_lr   += int'(latch_reset);
    cnt_wait += int'(!wait_n);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // hold iorq&&rd for n falling edges, optionally fire set pulses in the DONE cycle
  task automatic do_read(input logic m, input int n, input logic [7:0] exp_d,
                         input bit vb_done, input bit co_done);
    @(posedge phi); iorq = 1; rd = 1; mode = m;
    for (int k = 1; k <= n; k++) begin
      @(posedge phi);
      if (k < n) begin
        #3;
        chk("read dout", dout, exp_d);
        chk("read oe", {7'd0, dout_oe}, 8'h01);
      end
    end
    iorq = 0; rd = 0;
    @(posedge phi); vblank_set = vb_done; coinc_set = co_done;
    @(posedge phi); vblank_set = 0; coinc_set = 0;
  endtask

  int t0, l0, w0;

  initial begin
    repeat (2) @(posedge phi);
    #3;
    chk("reset dout", dout, 8'h00);
    chk("reset oe", {7'd0, dout_oe}, 8'h00);
    chk("reset int_n", {7'd0, int_n}, 8'h01);
    chk("reset wait_n", {7'd0, wait_n}, 8'h01);
    chk("reset status", dut.status, 8'h00);
    @(posedge phi); reset_n = 1;

    // status read returns F and clears it
    @(posedge phi); ie = 1; vblank_set = 1;
    @(posedge phi); vblank_set = 0;
    #3 chk("vblank int_n", {7'd0, int_n}, 8'h00);
    t0 = cnt_tick; l0 = cnt_lr;
    do_read(1'b1, 3, 8'h80, 0, 0);
    #3;
    chk("stat clr status", dut.status, 8'h00);
    chk("stat clr int_n", {7'd0, int_n}, 8'h01);
    chk("stat lr pulses", 8'(cnt_lr - l0), 8'd1);
    chk("stat tick pulses", 8'(cnt_tick - t0), 8'd0);

    // data read
    @(posedge phi); buf_data = 8'hA5; buf_valid = 1;
    t0 = cnt_tick; l0 = cnt_lr;
    do_read(1'b0, 3, 8'hA5, 0, 0);
    #3;
    chk("data tick pulses", 8'(cnt_tick - t0), 8'd1);
    chk("data lr pulses", 8'(cnt_lr - l0), 8'd1);
    chk("data status", dut.status, 8'h00);

    // set beats clear in the DONE cycle
    @(posedge phi); coinc_set = 1;
    @(posedge phi); coinc_set = 0;
    #3 chk("coinc status", dut.status, 8'h20);
    do_read(1'b1, 2, 8'h20, 1, 1);
    #3 chk("collision status", dut.status, 8'hA0);
    do_read(1'b1, 2, 8'hA0, 0, 0);
    #3 chk("collision cleared", dut.status, 8'h00);

    // fifth sprite number freezes while 5S is set
    @(posedge phi); fifth_set = 1; fifth_num = 5'd3;
    @(posedge phi); fifth_num = 5'd9;
    @(posedge phi); fifth_set = 0;
    #3 chk("fifth status", dut.status, 8'h43);
    do_read(1'b1, 2, 8'h43, 0, 0);
    #3 chk("fifth after read", dut.status, 8'h03);

    // aborted read: one edge only
    t0 = cnt_tick; l0 = cnt_lr;
    @(posedge phi); iorq = 1; rd = 1; mode = 0;
    @(posedge phi); iorq = 0; rd = 0;
    repeat (3) @(posedge phi);
    #3;
    chk("abort tick", 8'(cnt_tick - t0), 8'd0);
    chk("abort lr", 8'(cnt_lr - l0), 8'd0);
    chk("abort status", dut.status, 8'h03);

    // reset during HOLD
    t0 = cnt_tick; l0 = cnt_lr;
    @(posedge phi); iorq = 1; rd = 1; mode = 0;
    repeat (3) @(posedge phi);
    #4 reset_n = 0;
    #1 chk("rst oe", {7'd0, dout_oe}, 8'h00);
    @(posedge phi); iorq = 0; rd = 0;
    #4 reset_n = 1;
    repeat (3) @(posedge phi);
    #3;
    chk("rst tick", 8'(cnt_tick - t0), 8'd0);
    chk("rst lr", 8'(cnt_lr - l0), 8'd0);
    chk("rst dout", dout, 8'h00);

    // data read with the buffer empty for the first five edges
    @(posedge phi); ie = 0; buf_valid = 0; buf_data = 8'h11;
    t0 = cnt_tick; w0 = cnt_wait;
    @(posedge phi); iorq = 1; rd = 1; mode = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge phi);
      if (k == 5) begin buf_valid = 1; buf_data = 8'h5C; end
      if (k == 7) #3 chk("wait dout", dout, WEN ? 8'h5C : 8'h11);
    end
    iorq = 0; rd = 0;
    repeat (2) @(posedge phi);
    #3;
    chk("wait cycles", 8'(cnt_wait - w0), WEN ? 8'd4 : 8'd0);
    chk("wait tick", 8'(cnt_tick - t0), 8'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge phi);
      vblank_set = ($urandom_range(0, 15) == 0);
      coinc_set  = ($urandom_range(0, 15) == 0);
      fifth_set  = ($urandom_range(0, 15) == 0);
      fifth_num  = 5'($urandom);
      if ($urandom_range(0, 31) == 0) ie = ~ie;
      buf_data  = 8'($urandom);
      buf_valid = ($urandom_range(0, 3) != 0);
      if (iorq && rd) begin
        if ($urandom_range(0, 3) == 0) begin iorq = 0; rd = 0; end
      end else if ($urandom_range(0, 2) == 0) begin
        iorq = 1; rd = 1; mode = 1'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        #4 reset_n = 0;
        @(posedge phi);
        #4 reset_n = 1;
      end
    end
    repeat (3) @(posedge phi);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vdp_cpu_rd.md
Name: vdp_cpu_rd

Overview:
- CPU-read responder for the nouveau-vdp99: it services Z8S180 I/O read cycles (IOC=1 timing) on the VDP data port (mode=0) and status port (mode=1).
- It is the read-side counterpart of the VDP's I/O write capture path.
- It owns the status register (F, 5S, C, fifth-sprite number), drives the CPU data bus, and tells the VRAM fetcher to advance the read-ahead buffer.
- It clears the status flags and the address-write latch flip-flop when a read completes.

Parameters:
- STATUS_RST, 8'h00, reset value of the status register.

Ports:
- phi  input  1  CPU phi clock; all state updates on falling edge.
- reset_n  input  1  asynchronous, active-low reset.
- iorq  input  1  positive-logic, decoded VDP chip-select IORQ.
- rd  input  1  positive-logic RD.
- mode  input  1  port select, CPU A0: 0=data, 1=status.
- buf_data  input  8  VRAM read-ahead byte.
- buf_valid  input  1  buf_data holds a fetched byte.
- vblank_set  input  1  one-phi pulse, sets F.
- coinc_set  input  1  one-phi pulse, sets C.
- fifth_set  input  1  one-phi pulse, sets 5S.
- fifth_num  input  5  sprite number that accompanies fifth_set.
- ie  input  1  interrupt enable (VDP reg1 bit5).
- dout  output  8  read data.
- dout_oe  output  1  bus drive enable.
- rd_tick  output  1  one-phi pulse after a completed data-port read; fetcher increments the address and refetches.
- latch_reset  output  1  one-phi pulse after any completed read; clears the address-write flip-flop.
- int_n  output  1  active-low interrupt, = ~(F & ie).
- wait_n  output  1  active-low CPU WAIT.

Behaviour:
- Clock and reset: one clock, phi. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, status=STATUS_RST, dout=0, dout_oe=0, rd_tick=0, latch_reset=0, wait_n=1, int_n=1 (with the default STATUS_RST).
- State register: 3 bits, advances on negedge phi. States are IDLE, T1, WAIT, HOLD, DONE.
- IDLE:
  - Goes to T1 when iorq&&rd.
  - On that edge: if mode=1, dout <= status. If mode=0, dout <= buf_data.
  - mode is latched into mode_q on the same edge.
- T1:
  - If !(iorq&&rd): return to IDLE. This is an aborted read with no side effects.
  - Else if mode_q=0 and !buf_valid: go to WAIT. This only happens with the feature compiled in; otherwise it goes to HOLD.
  - Else: go to HOLD.
- WAIT:
  - wait_n=0 (combinational from state).
  - dout <= buf_data on every edge.
  - Go to HOLD when buf_valid.
  - If iorq&&rd drops: go to IDLE with no side effects.
- HOLD: stays while iorq&&rd, then goes to DONE.
- DONE:
  - One phi cycle; unconditionally returns to IDLE.
  - latch_reset=1.
  - rd_tick=1 if mode_q=0.
  - If mode_q=1, F, 5S and C are cleared.
  - A new iorq&&rd seen while in DONE is accepted from IDLE on the next edge.
- dout_oe = (state is T1, WAIT or HOLD) && iorq && rd. It drops combinationally the moment the CPU releases RD or IORQ.
- Status snapshot: dout keeps the value captured on entry. A flag set after the snapshot is not visible in this read.
- Status clear versus set:
  - A set pulse arriving in the same phi cycle as the DONE clear wins; that bit stays 1.
  - Only bits that were 1 in the snapshot are cleared. A flag set after the snapshot survives.
- fifth_num: latched into status[4:0] on fifth_set only while 5S=0. It is frozen while 5S=1.
- Status byte layout: {F, 5S, C, num[4:0]}.
- rd_tick and latch_reset are registered outputs, never asserted outside DONE.
- Reset asserted mid-read: the block returns to IDLE immediately, dout_oe=0 and no pulses are generated.

Optional Feature:
- Macro: VDP_RD_WAIT_EN.
- Defined: a data-port read with buf_valid=0 in T1 enters WAIT and holds the CPU until the buffer is valid, so the correct byte is always returned.
- Undefined: the WAIT state is not built, wait_n is tied to 1, and T1 goes straight to HOLD. The byte returned is whatever buf_data held at snapshot time, which may be stale.

Decomposition:
- Shared package vdp_pkg:
  - state encodings ST_IDLE=0, ST_T1=1, ST_WAIT=2, ST_HOLD=3, ST_DONE=4.
  - status bit indices STAT_F=7, STAT_5S=6, STAT_C=5.
  - PORT_DATA=0, PORT_STATUS=1.
- Sub-module vdp_status_reg: flag set/clear logic with set-over-clear priority and the snapshot mask.
- vdp_cpu_rd: the FSM and bus logic.

Test Plan:
- Status read:
  - Stimulus: vblank_set pulse; ie=1; then a mode=1 read of 3 phi cycles.
  - Response: int_n=0 before the read; dout=8'h80 with dout_oe=1 during the read.
  - After DONE: latch_reset pulses for 1 cycle, status=8'h00 and int_n=1.
- Data read:
  - Stimulus: buf_data=8'hA5, buf_valid=1, mode=0 read.
  - Response: dout=8'hA5; exactly one rd_tick and one latch_reset after RD deasserts; status unchanged.
- Set/clear collision:
  - Stimulus: status=8'h20 (C); status read; coinc_set and vblank_set fire in the DONE cycle.
  - Response: status=8'hA0 afterwards.
- Fifth sprite freeze:
  - Stimulus: fifth_set with num=5'd3, then fifth_set with num=5'd9.
  - Response: status=8'h43.
  - After a status read: status=8'h03. The number is retained; only the flag clears.
- Aborted read and reset:
  - Stimulus: iorq&&rd held for 1 falling edge only.
  - Response: no rd_tick, no latch_reset, status unchanged.
  - Stimulus: reset_n low during HOLD.
  - Response: dout_oe=0 immediately, state=IDLE, no pulses.
- With VDP_RD_WAIT_EN:
  - Stimulus: mode=0 read with buf_valid=0 for 4 edges, then buf_valid=1 with buf_data=8'h5C.
  - Response: wait_n=0 for 4 cycles, then dout=8'h5C and one rd_tick.
- Without VDP_RD_WAIT_EN, same stimulus:
  - Response: wait_n stays 1 and dout shows the old buf_data.
